// File: rtl/ipv4_tx_pkg.sv
// Shared types and constants for the Ethernet/IPv4 frame transmitter.
package ipv4_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ETH_HDR,
        ST_IP_HDR,
        ST_PAYLOAD,
        ST_PAD
    } tx_state_e;

    localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL      = 8'h45;
    localparam int          ETH_HDR_BYTES   = 14;
    localparam int          IP_HDR_BYTES    = 20;
    localparam int          MIN_ETH_PAYLOAD = 46;
    localparam int          MAX_PAYLOAD     = 64;
    localparam int          CSUM_WORDS      = 9;

    // Zero bytes needed after the payload to reach the 46 B minimum Ethernet payload.
    function automatic int pad_beats(input int payload, input bit pad_to_min);
        int room;
        room = MIN_ETH_PAYLOAD - IP_HDR_BYTES - payload;
        return (pad_to_min && room > 0) ? room : 0;
    endfunction

endpackage

// File: rtl/ipv4_checksum_accum.sv
// Sequential 16-bit ones'-complement accumulator, one word per clock.
module ipv4_checksum_accum (
    input  logic        CLK,
    input  logic        ARESET,
    input  logic        CLEAR,
    input  logic        WORD_VALID,
    input  logic [15:0] WORD,
    output logic [15:0] SUM
);

    logic [15:0] sum_q, sum_d;
    logic [16:0] raw;

    // Folding the carry straight back in cannot overflow a second time.
    always_comb begin
        raw   = {1'b0, sum_q} + {1'b0, WORD};
        sum_d = sum_q;
        if (CLEAR)
            sum_d = '0;
        else if (WORD_VALID)
            sum_d = raw[15:0] + {15'd0, raw[16]};
    end

    always_ff @(posedge CLK or negedge ARESET) begin
        if (!ARESET) sum_q <= '0;
        else         sum_q <= sum_d;
    end

    assign SUM = sum_q;

endmodule

// File: rtl/ipv4_frame_tx.sv
// Ethernet/IPv4 frame transmitter: latches addresses and message on START, then streams
// the frame one byte per AXI-S beat with registered tdata/tvalid/tlast/tuser.
module ipv4_frame_tx import ipv4_tx_pkg::*; #(
    parameter int         PAYLOAD_BYTES = 2,
    parameter int         MSG_WIDTH     = 16,
    parameter logic [7:0] TTL           = 8'h80,
    parameter logic [7:0] PROTOCOL      = 8'h04,
    parameter int         PAD_TO_MIN    = 1
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [31:0]          ACCELERATOR_IP_ADDRESS,
    input  logic [47:0]          ACCELERATOR_MAC_ADDRESS,
    input  logic [31:0]          RECIPIENT_IP_ADDRESS,
    input  logic [47:0]          RECIPIENT_MAC_ADDRESS,
    input  logic [MSG_WIDTH-1:0] RECIPIENT_MESSAGE,
    input  logic                 START_IP_TXN,
    input  logic                 ABORT_TXN,
    output logic                 READY_FOR_SEND,
    output logic [7:0]           MAC_DATA_OUT,
    output logic                 MAC_DATA_VALID,
    input  logic                 MAC_DATA_READY,
    output logic                 MAC_DATA_LAST,
    output logic                 MAC_DATA_TUSER,
    output logic [15:0]          FRAME_ID
);

    localparam int              PW        = 8 * PAYLOAD_BYTES;
    localparam int              CW        = $clog2(ETH_HDR_BYTES + IP_HDR_BYTES + MAX_PAYLOAD + 26);
    localparam int              PAD_BEATS = pad_beats(PAYLOAD_BYTES, PAD_TO_MIN != 0);
    localparam logic [15:0]     TOTAL_LEN = 16'(IP_HDR_BYTES + PAYLOAD_BYTES);
    localparam tx_state_e       LAST_ST   = (PAD_BEATS > 0) ? ST_PAD : ST_PAYLOAD;
    localparam logic [CW-1:0]   LAST_CNT  = CW'((PAD_BEATS > 0) ? PAD_BEATS - 1 : PAYLOAD_BYTES - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [47:0]   dmac_q, dmac_d, smac_q, smac_d;
    logic [31:0]   sip_q, sip_d, dip_q, dip_d;
    logic [PW-1:0] pay_q, pay_d;
    logic [15:0]   ident_q, ident_d, frame_id_q, frame_id_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d, last_q, last_d, tuser_q, tuser_d;
    logic          rfs_q, rfs_d, abort_pend_q, abort_pend_d;
    logic [3:0]    wcnt_q, wcnt_d;

    logic          ck_clear, ck_valid;
    logic [15:0]   ck_word, ck_sum;

    tx_state_e     adv_state;
    logic [CW-1:0] adv_cnt;
    logic [7:0]    adv_byte;
    logic          adv_last;
    logic          xfer, abort_now;

    logic [8*ETH_HDR_BYTES-1:0] eth_hdr, eth_sh;
    logic [8*IP_HDR_BYTES-1:0]  ip_hdr, ip_sh;
    logic [PW-1:0]              pay_sh;
    int                         c;

    ipv4_checksum_accum u_csum (
        .CLK        (ACLK),
        .ARESET     (ARESET),
        .CLEAR      (ck_clear),
        .WORD_VALID (ck_valid),
        .WORD       (ck_word),
        .SUM        (ck_sum)
    );

    assign eth_hdr = {dmac_q, smac_q, ETHERTYPE_IPV4};
    assign ip_hdr  = {IP_VER_IHL, 8'h00, TOTAL_LEN, frame_id_q, 16'h0000, TTL, PROTOCOL,
                      ~ck_sum, sip_q, dip_q};

    // Position of the beat that follows the one currently on the bus.
    always_comb begin
        adv_state = state_q;
        adv_cnt   = cnt_q + CW'(1);
        case (state_q)
            ST_ETH_HDR: if (cnt_q == CW'(ETH_HDR_BYTES - 1)) begin adv_state = ST_IP_HDR;  adv_cnt = '0; end
            ST_IP_HDR:  if (cnt_q == CW'(IP_HDR_BYTES - 1))  begin adv_state = ST_PAYLOAD; adv_cnt = '0; end
            ST_PAYLOAD: if (cnt_q == CW'(PAYLOAD_BYTES - 1)) begin adv_state = ST_PAD;     adv_cnt = '0; end
            default: ;
        endcase
    end

    always_comb begin
        c        = int'(adv_cnt);
        eth_sh   = eth_hdr << (8 * c);
        ip_sh    = ip_hdr << (8 * c);
        pay_sh   = pay_q << (8 * c);
        adv_byte = 8'h00;
        case (adv_state)
            ST_ETH_HDR: adv_byte = eth_sh[8*ETH_HDR_BYTES-1 -: 8];
            ST_IP_HDR:  adv_byte = ip_sh[8*IP_HDR_BYTES-1 -: 8];
            ST_PAYLOAD: adv_byte = pay_sh[PW-1 -: 8];
            default:    adv_byte = 8'h00;
        endcase
        adv_last = (adv_state == LAST_ST) && (adv_cnt == LAST_CNT);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dmac_d       = dmac_q;
        smac_d       = smac_q;
        sip_d        = sip_q;
        dip_d        = dip_q;
        pay_d        = pay_q;
        ident_d      = ident_q;
        frame_id_d   = frame_id_q;
        data_d       = data_q;
        valid_d      = valid_q;
        last_d       = last_q;
        tuser_d      = tuser_q;
        rfs_d        = rfs_q;
        abort_pend_d = abort_pend_q;
        wcnt_d       = wcnt_q;
        ck_clear     = 1'b0;
        ck_valid     = 1'b0;
        ck_word      = 16'h0000;
        xfer         = valid_q & MAC_DATA_READY;
        abort_now    = abort_pend_q | ABORT_TXN;

        // Header words fed one per clock; done long before the checksum byte is emitted.
        if (wcnt_q < 4'(CSUM_WORDS)) begin
            ck_valid = 1'b1;
            wcnt_d   = wcnt_q + 4'd1;
            case (wcnt_q)
                4'd0:    ck_word = {IP_VER_IHL, 8'h00};
                4'd1:    ck_word = TOTAL_LEN;
                4'd2:    ck_word = frame_id_q;
                4'd3:    ck_word = 16'h0000;
                4'd4:    ck_word = {TTL, PROTOCOL};
                4'd5:    ck_word = sip_q[31:16];
                4'd6:    ck_word = sip_q[15:0];
                4'd7:    ck_word = dip_q[31:16];
                default: ck_word = dip_q[15:0];
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (START_IP_TXN) begin
                    dmac_d                  = RECIPIENT_MAC_ADDRESS;
                    smac_d                  = ACCELERATOR_MAC_ADDRESS;
                    sip_d                   = ACCELERATOR_IP_ADDRESS;
                    dip_d                   = RECIPIENT_IP_ADDRESS;
                    pay_d                   = '0;
                    pay_d[MSG_WIDTH-1:0]    = RECIPIENT_MESSAGE;
                    frame_id_d              = ident_q;
                    state_d                 = ST_ETH_HDR;
                    cnt_d                   = '0;
                    data_d                  = RECIPIENT_MAC_ADDRESS[47:40];
                    valid_d                 = 1'b1;
                    last_d                  = 1'b0;
                    tuser_d                 = 1'b0;
                    rfs_d                   = 1'b0;
                    abort_pend_d            = 1'b0;
                    ck_clear                = 1'b1;
                    ck_valid                = 1'b0;
                    wcnt_d                  = 4'd0;
                end
            end
            default: begin
                if (xfer && last_q) begin
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    data_d       = 8'h00;
                    valid_d      = 1'b0;
                    last_d       = 1'b0;
                    tuser_d      = 1'b0;
                    rfs_d        = 1'b1;
                    abort_pend_d = 1'b0;
                    ident_d      = ident_q + 16'd1;
                end else if (xfer) begin
                    state_d      = adv_state;
                    cnt_d        = adv_cnt;
                    data_d       = adv_byte;
                    last_d       = adv_last | abort_now;
                    tuser_d      = abort_now;
                    abort_pend_d = 1'b0;
                end else if (ABORT_TXN && !last_q) begin
                    // Held beat stays untouched; the abort marks the next beat loaded.
                    abort_pend_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dmac_q       <= '0;
            smac_q       <= '0;
            sip_q        <= '0;
            dip_q        <= '0;
            pay_q        <= '0;
            ident_q      <= '0;
            frame_id_q   <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            tuser_q      <= 1'b0;
            rfs_q        <= 1'b1;
            abort_pend_q <= 1'b0;
            wcnt_q       <= 4'(CSUM_WORDS);
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dmac_q       <= dmac_d;
            smac_q       <= smac_d;
            sip_q        <= sip_d;
            dip_q        <= dip_d;
            pay_q        <= pay_d;
            ident_q      <= ident_d;
            frame_id_q   <= frame_id_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            tuser_q      <= tuser_d;
            rfs_q        <= rfs_d;
            abort_pend_q <= abort_pend_d;
            wcnt_q       <= wcnt_d;
        end
    end

    assign READY_FOR_SEND = rfs_q;
    assign MAC_DATA_OUT   = data_q;
    assign MAC_DATA_VALID = valid_q;
    assign MAC_DATA_LAST  = last_q;
    assign MAC_DATA_TUSER = tuser_q;
    assign FRAME_ID       = frame_id_q;

endmodule

// File: tb/tb_ipv4_frame_tx.sv
// Bench for ipv4_frame_tx: three parameterisations, a frame-level model and a per-cycle compare.
module tb_ipv4_frame_tx;

    localparam int PB [3] = '{2, 40, 2};
    localparam int PD [3] = '{1, 1, 0};

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [47:0] dmac, smac;
    logic [31:0] sip, dip;
    logic [15:0] msg;
    logic        start [3];
    logic        abort [3];
    logic        rdy   [3];
    logic [7:0]  dout  [3];
    logic        vout  [3];
    logic        lout  [3];
    logic        tout  [3];
    logic        rfs   [3];
    logic [15:0] fid   [3];

    int npass = 0, ntot = 0;
    bit rnd_en = 1'b0;

    // model state
    bit          idle_m [3];
    bit          pend_m [3];
    bit          ab_m   [3];
    int          idx_m  [3];
    int          len_m  [3];
    int          acc_m  [3];
    logic [15:0] ident_m [3];
    logic [15:0] fid_m   [3];
    logic [7:0]  exp_q [3][$];
    logic [7:0]  cap   [3][$];
    bit          cap_tuser [3];
    bit          prev_stall [3];
    logic [7:0]  prev_d [3];
    bit          prev_l [3];
    logic [7:0]  t1 [$];

    always #5 ACLK = ~ACLK;

    ipv4_frame_tx #(.PAYLOAD_BYTES(2), .PAD_TO_MIN(1)) u0 (
        .ACLK(ACLK), .ARESET(ARESET), .ACCELERATOR_IP_ADDRESS(sip), .ACCELERATOR_MAC_ADDRESS(smac),
        .RECIPIENT_IP_ADDRESS(dip), .RECIPIENT_MAC_ADDRESS(dmac), .RECIPIENT_MESSAGE(msg),
        .START_IP_TXN(start[0]), .ABORT_TXN(abort[0]), .READY_FOR_SEND(rfs[0]), .MAC_DATA_OUT(dout[0]),
        .MAC_DATA_VALID(vout[0]), .MAC_DATA_READY(rdy[0]), .MAC_DATA_LAST(lout[0]),
        .MAC_DATA_TUSER(tout[0]), .FRAME_ID(fid[0]));

    ipv4_frame_tx #(.PAYLOAD_BYTES(40), .PAD_TO_MIN(1)) u1 (
        .ACLK(ACLK), .ARESET(ARESET), .ACCELERATOR_IP_ADDRESS(sip), .ACCELERATOR_MAC_ADDRESS(smac),
        .RECIPIENT_IP_ADDRESS(dip), .RECIPIENT_MAC_ADDRESS(dmac), .RECIPIENT_MESSAGE(msg),
        .START_IP_TXN(start[1]), .ABORT_TXN(abort[1]), .READY_FOR_SEND(rfs[1]), .MAC_DATA_OUT(dout[1]),
        .MAC_DATA_VALID(vout[1]), .MAC_DATA_READY(rdy[1]), .MAC_DATA_LAST(lout[1]),
        .MAC_DATA_TUSER(tout[1]), .FRAME_ID(fid[1]));

    ipv4_frame_tx #(.PAYLOAD_BYTES(2), .PAD_TO_MIN(0)) u2 (
        .ACLK(ACLK), .ARESET(ARESET), .ACCELERATOR_IP_ADDRESS(sip), .ACCELERATOR_MAC_ADDRESS(smac),
        .RECIPIENT_IP_ADDRESS(dip), .RECIPIENT_MAC_ADDRESS(dmac), .RECIPIENT_MESSAGE(msg),
        .START_IP_TXN(start[2]), .ABORT_TXN(abort[2]), .READY_FOR_SEND(rfs[2]), .MAC_DATA_OUT(dout[2]),
        .MAC_DATA_VALID(vout[2]), .MAC_DATA_READY(rdy[2]), .MAC_DATA_LAST(lout[2]),
        .MAC_DATA_TUSER(tout[2]), .FRAME_ID(fid[2]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        ntot++;
        if (act === want) npass++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    endtask

    task automatic push_bytes(input int d, input logic [511:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q[d].push_back(8'(v >> (8 * (n - 1 - i))));
    endtask

    // Whole expected frame from the field layout; checksum folded once at the end.
    task automatic build(input int d, input logic [15:0] id);
        logic [15:0] w [9];
        int          s, tl, np;
        logic [15:0] cs;
        tl = 20 + PB[d];
        w  = '{16'h4500, 16'(tl), id, 16'h0000, 16'h8004, sip[31:16], sip[15:0], dip[31:16], dip[15:0]};
        s  = 0;
        for (int i = 0; i < 9; i++) s += int'(w[i]);
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        cs = ~16'(s);
        exp_q[d].delete();
        push_bytes(d, 512'({dmac, smac, 16'h0800}), 14);
        push_bytes(d, 512'({8'h45, 8'h00, 16'(tl), id, 16'h0000, 8'h80, 8'h04, cs, sip, dip}), 20);
        push_bytes(d, 512'(msg), PB[d]);
        np = (PD[d] != 0 && 26 - PB[d] > 0) ? 26 - PB[d] : 0;
        for (int i = 0; i < np; i++) exp_q[d].push_back(8'h00);
        len_m[d] = exp_q[d].size();
    endtask

    always @(negedge ACLK) begin
        for (int d = 0; d < 3; d++) begin
            if (!ARESET) begin
                idle_m[d] = 1'b1; pend_m[d] = 1'b0; ab_m[d] = 1'b0; idx_m[d] = 0;
                ident_m[d] = 16'h0; fid_m[d] = 16'h0; prev_stall[d] = 1'b0;
                chk("rst_valid", vout[d], 0);
                chk("rst_last", lout[d], 0);
                chk("rst_tuser", tout[d], 0);
                chk("rst_data", dout[d], 0);
                chk("rst_rfs", rfs[d], 1);
                chk("rst_frame_id", fid[d], 0);
            end else begin
                chk("frame_id", fid[d], fid_m[d]);
                if (prev_stall[d]) begin
                    chk("stall_data", dout[d], prev_d[d]);
                    chk("stall_last", lout[d], prev_l[d]);
                end
                if (idle_m[d]) begin
                    chk("idle_valid", vout[d], 0);
                    chk("idle_rfs", rfs[d], 1);
                    prev_stall[d] = 1'b0;
                    if (start[d]) begin
                        build(d, ident_m[d]);
                        fid_m[d] = ident_m[d]; idle_m[d] = 1'b0; idx_m[d] = 0;
                        pend_m[d] = 1'b0; ab_m[d] = 1'b0; acc_m[d]++;
                    end
                end else begin
                    bit cl;
                    cl = (idx_m[d] == len_m[d] - 1);
                    chk("valid", vout[d], 1);
                    chk("busy_rfs", rfs[d], 0);
                    chk("data", dout[d], exp_q[d][idx_m[d]]);
                    chk("last", lout[d], cl);
                    chk("tuser", tout[d], cl && ab_m[d]);
                    prev_stall[d] = vout[d] && !rdy[d];
                    prev_d[d] = dout[d];
                    prev_l[d] = lout[d];
                    if (vout[d] && rdy[d]) begin
                        cap[d].push_back(dout[d]);
                        if (cl) begin
                            idle_m[d] = 1'b1; ident_m[d] = ident_m[d] + 16'd1; cap_tuser[d] = tout[d];
                        end else begin
                            idx_m[d]++;
                            if (pend_m[d] || abort[d]) begin
                                len_m[d] = idx_m[d] + 1; ab_m[d] = 1'b1; pend_m[d] = 1'b0;
                            end
                        end
                    end else if (abort[d] && !cl) begin
                        pend_m[d] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) rdy[d] = 1'b1;
        forever begin
            @(posedge ACLK); #1;
            rdy[0] = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
            rdy[1] = 1'b1;
            rdy[2] = 1'b1;
        end
    end

    task automatic clk1; @(posedge ACLK); #1; endtask

    task automatic do_reset;
        ARESET = 1'b0; repeat (3) clk1(); ARESET = 1'b1; clk1();
    endtask

    task automatic send(input int d);
        start[d] = 1'b1; clk1(); start[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int budget);
        int n = 0;
        while (!idle_m[d] && n < budget) begin clk1(); n++; end
        chk("frame_done_in_time", idle_m[d], 1);
    endtask

    task automatic wait_idx(input int d, input int tgt, input int budget);
        int n = 0;
        while (idx_m[d] != tgt && n < budget) begin clk1(); n++; end
        chk("reach_beat", idx_m[d], tgt);
    endtask

    task automatic clear_caps;
        for (int d = 0; d < 3; d++) cap[d].delete();
    endtask

    initial begin
        int base, n, nd;
        ARESET = 1'b0;
        for (int d = 0; d < 3; d++) begin start[d] = 1'b0; abort[d] = 1'b0; acc_m[d] = 0; end
        dmac = 48'h02_00_00_00_00_01; smac = 48'h02_00_00_00_00_02;
        sip  = 32'hC0A80001;          dip  = 32'hC0A80002;
        msg  = 16'h03FF;
        repeat (3) clk1();
        chk("por_rfs", rfs[0], 1);
        chk("por_valid", vout[0], 0);
        ARESET = 1'b1; clk1();

        // 1: default frame, no stalls
        clear_caps(); send(0); wait_idle(0, 200);
        chk("t1_len", cap[0].size(), 60);
        chk("t1_ethertype", {cap[0][12], cap[0][13]}, 16'h0800);
        chk("t1_total_len", {cap[0][16], cap[0][17]}, 16'h0016);
        chk("t1_ident", {cap[0][18], cap[0][19]}, 16'h0000);
        chk("t1_csum", {cap[0][24], cap[0][25]}, 16'hB990);
        chk("t1_payload", {cap[0][34], cap[0][35]}, 16'h03FF);
        nd = 0;
        for (int i = 36; i < 60; i++) if (cap[0][i] == 8'h00) nd++;
        chk("t1_pad_zero", nd, 24);
        t1 = cap[0];

        // 2: same frame under random backpressure
        do_reset(); clear_caps(); rnd_en = 1'b1; send(0); wait_idle(0, 3000); rnd_en = 1'b0;
        nd = 0;
        for (int i = 0; i < 60 && i < cap[0].size(); i++) if (cap[0][i] != t1[i]) nd++;
        chk("t2_len", cap[0].size(), 60);
        chk("t2_same_stream", nd, 0);

        // 3: three frames back to back
        do_reset(); clear_caps();
        base = acc_m[0]; n = 0; start[0] = 1'b1;
        while (acc_m[0] < base + 3 && n < 1000) begin clk1(); n++; end
        start[0] = 1'b0;
        wait_idle(0, 200);
        chk("t3_len", cap[0].size(), 180);
        for (int f = 0; f < 3; f++) chk("t3_ident", {cap[0][60*f+18], cap[0][60*f+19]}, 16'(f));
        chk("t3_csum1", {cap[0][84], cap[0][85]}, 16'hB98F);
        chk("t3_csum2", {cap[0][144], cap[0][145]}, 16'hB98E);
        chk("t3_frame_id", fid[0], 16'h0002);

        // 4: abort so beat 20 closes the frame
        clear_caps(); send(0); wait_idx(0, 19, 100);
        abort[0] = 1'b1; clk1(); abort[0] = 1'b0;
        wait_idle(0, 100);
        chk("t4_len", cap[0].size(), 21);
        chk("t4_tuser", cap_tuser[0], 1);
        chk("t4_rfs_next", rfs[0], 1);
        clear_caps(); send(0); wait_idle(0, 200);
        chk("t4_next_ident", {cap[0][18], cap[0][19]}, 16'h0004);

        // 5: long payload without pad, and no padding at all
        clear_caps(); start[1] = 1'b1; start[2] = 1'b1; clk1(); start[1] = 1'b0; start[2] = 1'b0;
        wait_idle(1, 200); wait_idle(2, 200);
        chk("t5_long_len", cap[1].size(), 74);
        chk("t5_long_total_len", {cap[1][16], cap[1][17]}, 16'h003C);
        chk("t5_long_tail", {cap[1][72], cap[1][73]}, 16'h03FF);
        chk("t5_nopad_len", cap[2].size(), 36);

        // 6: reset in the middle of a frame
        do_reset(); clear_caps(); send(0); wait_idx(0, 30, 100);
        #2 ARESET = 1'b0;
        #1 chk("t6_async_valid", vout[0], 0);
        chk("t6_async_rfs", rfs[0], 1);
        repeat (2) clk1(); ARESET = 1'b1; clk1();
        clear_caps(); send(0); wait_idle(0, 200);
        chk("t6_len", cap[0].size(), 60);
        chk("t6_ident", {cap[0][18], cap[0][19]}, 16'h0000);
        chk("t6_csum", {cap[0][24], cap[0][25]}, 16'hB990);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
